// File: rtl/rw_manager_ac_rom_reader.sv
// Read-side sequencer for the address/command instruction ROM.
// Fetches a contiguous, wrapping run of AC words from a ROM with a fixed read
// latency. A small output buffer absorbs that latency. Words are presented
// in issue order on a valid/ready stream, with the command fields split out.
module rw_manager_ac_rom_reader #(
  parameter int ADDR_W    = 6,
  parameter int DATA_W    = 32,
  parameter int ROM_LAT   = 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_rdaddress,
  input  logic [DATA_W-1:0] rom_q,
  output logic              ac_valid,
  input  logic              ac_ready,
  output logic [DATA_W-1:0] ac_word,
  output logic [3:0]        ac_cmd,
  output logic [7:0]        ac_ctl,
  output logic [15:0]       ac_addr
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int LAT_W = $clog2(ROM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [CNT_W-1:0]  issue_left_q;
  logic [CNT_W-1:0]  accept_left_q;
  logic [ROM_LAT-1:0] pipe_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [OCC_W-1:0]  occ_q;
  logic [DATA_W-1:0] mem_q [BUF_DEPTH];

  logic [LAT_W-1:0]  in_flight;
  logic              issue;
  logic              buf_wr;
  logic              buf_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Number of issued reads whose data has not yet reached the buffer.
  // NOTE: the default assignment first means every path drives in_flight, so no latch is inferred.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < ROM_LAT; i++) begin
      in_flight = in_flight + LAT_W'(pipe_q[i]);
    end
  end

  // A read may issue only while buffer plus in-flight words leave room for its data.
  assign issue = (state_q == S_FETCH) && (issue_left_q != '0) &&
                 ((32'(occ_q) + 32'(in_flight)) < 32'(BUF_DEPTH));

  assign buf_wr   = pipe_q[ROM_LAT-1];
  assign ac_valid = (occ_q != '0);
  assign buf_pop  = ac_valid && ac_ready;

  // The ROM registers its address itself. Presenting the pointer in the issue
  // cycle keeps the latency at ROM_LAT. Otherwise the last address is held.
  assign rom_rdaddress = issue ? ptr_q : addr_hold_q;

  assign busy = (state_q == S_FETCH) || (state_q == S_DRAIN) ||
                ((state_q == S_IDLE) && start);
  assign done = (state_q == S_DONE);

  assign ac_word = mem_q[rd_ptr_q];
  assign ac_cmd  = ac_word[27:24];
  assign ac_ctl  = ac_word[23:16];
  assign ac_addr = ac_word[15:0];

  // Run control: accept a start, count issued and accepted words, pulse done.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      issue_left_q  <= '0;
      accept_left_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (word_count != '0) begin
              ptr_q         <= start_addr;
              issue_left_q  <= word_count;
              accept_left_q <= word_count;
              state_q       <= S_FETCH;
            end else begin
              state_q <= S_DONE;
            end
          end
        end
        S_FETCH: begin
          if (issue) begin
            ptr_q        <= ptr_q + 1'b1;
            issue_left_q <= issue_left_q - 1'b1;
            if (issue_left_q == CNT_W'(1)) state_q <= S_DRAIN;
          end
          if (buf_pop) accept_left_q <= accept_left_q - 1'b1;
        end
        S_DRAIN: begin
          if (buf_pop) begin
            accept_left_q <= accept_left_q - 1'b1;
            if (accept_left_q == CNT_W'(1)) state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Track outstanding ROM reads and remember the last address presented.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_q      <= '0;
      addr_hold_q <= '0;
    end else begin
      pipe_q <= (pipe_q << 1) | ROM_LAT'(issue);
      if (issue) addr_hold_q <= ptr_q;
    end
  end

  // Buffer pointers and occupancy. A write and a pop in the same cycle are both honoured.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (buf_wr)  wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (buf_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({buf_wr, buf_pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Buffer storage captures returning ROM data.
  // NOTE: the storage is not reset; the reset pointers and occupancy keep stale entries invisible.
  always_ff @(posedge clock) begin
    if (buf_wr) mem_q[wr_ptr_q] <= rom_q;
  end

endmodule

// File: tb/tb_rw_manager_ac_rom_reader.sv
// Directed bench for rw_manager_ac_rom_reader.
// The bench includes a 2-cycle registered ROM model. Expected words come from
// the bench's own ROM table and from hand-computed constants.
module tb_rw_manager_ac_rom_reader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [5:0]  start_addr;
  logic [6:0]  word_count;
  logic        busy;
  logic        done;
  logic [5:0]  rom_rdaddress;
  logic [31:0] rom_q;
  logic        ac_valid;
  logic        ac_ready;
  logic [31:0] ac_word;
  logic [3:0]  ac_cmd;
  logic [7:0]  ac_ctl;
  logic [15:0] ac_addr;

  typedef struct packed {
    logic [31:0] word;
    logic [3:0]  cmd;
    logic [7:0]  ctl;
    logic [15:0] addr;
  } beat_t;

  beat_t       got_q[$];
  logic [31:0] exp_q[$];
  logic [5:0]  addr_q[$];
  logic [5:0]  last_addr;
  int          done_cnt;
  bit          stall_prev;
  logic [31:0] held_word;
  int          n_tests;
  int          n_fail;

  logic [31:0] rom_mem [64];
  logic [5:0]  rom_addr_r = '0;

  always #5 clock = ~clock;

  rw_manager_ac_rom_reader #(
    .ADDR_W(6), .DATA_W(32), .ROM_LAT(2), .BUF_DEPTH(4)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .start_addr(start_addr),
    .word_count(word_count), .busy(busy), .done(done),
    .rom_rdaddress(rom_rdaddress), .rom_q(rom_q), .ac_valid(ac_valid),
    .ac_ready(ac_ready), .ac_word(ac_word), .ac_cmd(ac_cmd), .ac_ctl(ac_ctl),
    .ac_addr(ac_addr)
  );

  // ROM model: registered address, registered data.
  always @(posedge clock) begin
    rom_addr_r <= rom_rdaddress;
    rom_q      <= rom_mem[rom_addr_r];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Stream monitor: log accepted words, done pulses, and address changes, and check stall stability.
  always @(negedge clock) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(ac_valid), 32'd1);
        check("stall_word", ac_word, held_word);
      end
      if (ac_valid && ac_ready) got_q.push_back('{ac_word, ac_cmd, ac_ctl, ac_addr});
      if (done) done_cnt++;
      if (rom_rdaddress != last_addr) begin
        addr_q.push_back(rom_rdaddress);
        last_addr = rom_rdaddress;
      end
      stall_prev = ac_valid && !ac_ready;
      held_word  = ac_word;
    end
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [5:0] a, input logic [6:0] n);
    @(posedge clock);
    #1;
    got_q.delete();
    addr_q.delete();
    last_addr  = rom_rdaddress;
    done_cnt   = 0;
    start_addr = a;
    word_count = n;
    start      = 1'b1;
    @(negedge clock);
    check("busy_accept", 32'(busy), 32'd1);
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit toggle);
    bit seen = 1'b0;
    int cyc  = 0;
    while (!seen && cyc < budget) begin
      @(posedge clock);
      #1;
      cyc++;
      if (toggle) ac_ready = (cyc % 3 == 0);
      if (done) begin
        seen = 1'b1;
        check("done_busy", 32'(busy), 32'd0);
      end
    end
    if (!seen) check("done_timeout", 32'(seen), 32'd1);
    ac_ready = 1'b1;
  endtask

  task automatic check_run(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s_w%0d", tag, i), got_q[i].word, exp_q[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n;
    n_tests = 0;
    n_fail  = 0;
    done_cnt = 0;
    last_addr = '0;
    for (int i = 0; i < 64; i++) rom_mem[i] = 32'h0A00_0000 | 32'(i);
    rom_mem[0]  = 32'h0E07_0000; rom_mem[1]  = 32'h0F07_0000;
    rom_mem[2]  = 32'h0E07_0000; rom_mem[3]  = 32'h0C07_0000;
    rom_mem[4]  = 32'h0600_0433;
    for (int i = 5; i < 15; i++) rom_mem[i] = 32'h0650_0000 | 32'(i);
    rom_mem[15] = 32'h0799_0008;
    rom_mem[16] = 32'h0799_0000; rom_mem[17] = 32'h0799_4000;
    rom_mem[28] = 32'h0665_4008; rom_mem[29] = 32'h0E67_0000;
    rom_mem[30] = 32'h0605_0008;
    rom_mem[62] = 32'h0000_0000; rom_mem[63] = 32'h0000_0000;

    reset_n = 1'b0; start = 1'b0; start_addr = '0; word_count = '0; ac_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(ac_valid), 32'd0);
    check("rst_rdaddr", 32'(rom_rdaddress), 32'd0);
    reset_n = 1'b1;

    // Four words from address 0 with the stream always ready.
    do_start(6'h00, 7'd4);
    lat = -1;
    for (int i = 1; i <= 20 && lat < 0; i++) begin
      if (ac_valid) lat = i - 1;
      else begin
        @(posedge clock);
        #1;
        if (ac_valid) lat = i;
      end
    end
    check("t1_latency", 32'(lat), 32'd3);
    wait_done(100, 1'b0);
    settle(2);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    exp_q = '{32'h0E07_0000, 32'h0F07_0000, 32'h0E07_0000, 32'h0C07_0000};
    check_run("t1");

    // Field split on a mid-table run.
    do_start(6'h1C, 7'd3);
    wait_done(100, 1'b0);
    settle(2);
    exp_q = '{32'h0665_4008, 32'h0E67_0000, 32'h0605_0008};
    check_run("t2");
    if (got_q.size() > 1) begin
      check("t2_cmd", 32'(got_q[1].cmd), 32'h0000_000E);
      check("t2_ctl", 32'(got_q[1].ctl), 32'h0000_0067);
      check("t2_addr", 32'(got_q[1].addr), 32'h0000_0000);
    end

    // Address wrap from 0x3E.
    do_start(6'h3E, 7'd4);
    wait_done(100, 1'b0);
    settle(2);
    exp_q = '{32'h0000_0000, 32'h0000_0000, 32'h0E07_0000, 32'h0F07_0000};
    check_run("t3");
    check("t3_addr_count", 32'(addr_q.size()), 32'd4);
    if (addr_q.size() == 4) begin
      check("t3_addr0", 32'(addr_q[0]), 32'h3E);
      check("t3_addr1", 32'(addr_q[1]), 32'h3F);
      check("t3_addr2", 32'(addr_q[2]), 32'h00);
      check("t3_addr3", 32'(addr_q[3]), 32'h01);
    end
    check("t3_done_cnt", 32'(done_cnt), 32'd1);

    // Twelve words with a full stall first, then ready one cycle in three.
    ac_ready = 1'b0;
    do_start(6'h04, 7'd12);
    settle(10);
    check("t4_stall_rdaddr", 32'(rom_rdaddress), 32'h07);
    check("t4_stall_valid", 32'(ac_valid), 32'd1);
    check("t4_stall_word", ac_word, 32'h0600_0433);
    check("t4_stall_busy", 32'(busy), 32'd1);
    start_addr = 6'h30; word_count = 7'd5; start = 1'b1;
    settle(1);
    start = 1'b0;
    settle(2);
    check("t4_stray_rdaddr", 32'(rom_rdaddress), 32'h07);
    wait_done(400, 1'b1);
    settle(2);
    exp_q.delete();
    for (int i = 4; i < 16; i++) exp_q.push_back(rom_mem[i]);
    check_run("t4");
    check("t4_addr_count", 32'(addr_q.size()), 32'd12);
    check("t4_done_cnt", 32'(done_cnt), 32'd1);

    // Zero-length run.
    do_start(6'h2A, 7'd0);
    check("t5_done", 32'(done), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    settle(1);
    check("t5_done_low", 32'(done), 32'd0);
    check("t5_busy_low", 32'(busy), 32'd0);
    check("t5_rdaddr", 32'(rom_rdaddress), 32'h0F);
    settle(2);
    check("t5_addr_count", 32'(addr_q.size()), 32'd0);
    check("t5_word_count", 32'(got_q.size()), 32'd0);
    check("t5_done_cnt", 32'(done_cnt), 32'd1);

    // Reset in the middle of a 20-word run, then a fresh short run.
    do_start(6'h20, 7'd20);
    n = 0;
    while (got_q.size() < 5 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("t6_reach5", 32'(got_q.size() >= 5), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(ac_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_rdaddr", 32'(rom_rdaddress), 32'd0);
    exp_q.delete();
    for (int i = 32; i < 37; i++) exp_q.push_back(rom_mem[i]);
    check_run("t6a");
    @(negedge clock);
    reset_n = 1'b1;
    settle(2);
    check("t6_idle_valid", 32'(ac_valid), 32'd0);
    do_start(6'h10, 7'd2);
    wait_done(100, 1'b0);
    settle(2);
    exp_q = '{32'h0799_0000, 32'h0799_4000};
    check_run("t6b");
    check("t6_done_cnt", 32'(done_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rw_manager_ac_rom_reader.md
Name: rw_manager_ac_rom_reader

Overview:
Read-side sequencer for the 64x32 address/command instruction ROM (registered address, registered data, 2-cycle read latency). On a start request it fetches a contiguous run of AC words, absorbs the ROM latency through a 4-entry buffer, and presents each word on a valid/ready stream to the AC output path. It sits between the RW manager control FSM and the AC ROM.

Parameters:
ADDR_W, 6, ROM address width; the run wraps modulo 2^ADDR_W.
DATA_W, 32, ROM word width.
ROM_LAT, 2, cycles from rom_rdaddress to rom_q valid; fixed 2 for this ROM.
BUF_DEPTH, 4, output buffer entries; must be at least ROM_LAT+1.

Ports:
clock  in  1  single clock; also drives the ROM.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle request; accepted only in IDLE.
start_addr  in  ADDR_W  first ROM address of the run.
word_count  in  ADDR_W+1  words to read, 0..64.
busy  out  1  high from the accepted start until done.
done  out  1  one-cycle pulse when the last word has been accepted downstream.
rom_rdaddress  out  ADDR_W  to the ROM rdaddress input.
rom_q  in  DATA_W  from the ROM q output.
ac_valid  out  1  ac_word is valid.
ac_ready  in  1  downstream accepts when ac_valid && ac_ready.
ac_word  out  DATA_W  raw ROM word.
ac_cmd  out  4  ac_word[27:24], decoded command nibble.
ac_ctl  out  8  ac_word[23:16], control field.
ac_addr  out  16  ac_word[15:0], address/operand field.

Behaviour:
- Reset (async assert, sync deassert handled upstream): FSM=IDLE; busy=0, done=0, ac_valid=0, rom_rdaddress=0; buffer empty; all counters 0.
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE: on start with word_count!=0, latch start_addr into the fetch pointer and word_count into issue_left/accept_left, then go to FETCH with busy=1. If word_count==0, go straight to DONE with no ROM reads. A start in any other state is ignored.
- FETCH, issue rule: a read issues in a cycle only if issue_left>0 and (buffer occupancy + in_flight) < BUF_DEPTH. When it issues, drive rom_rdaddress=pointer, then increment pointer (wrapping 63 to 0), decrement issue_left, and record the issue in a ROM_LAT-deep valid shift pipe.
- A word returns as rom_q exactly ROM_LAT cycles after its issue cycle and is written into the buffer that cycle. Because of the credit check, the buffer never overflows and returning data is never dropped.
- rom_rdaddress holds its last value when no read issues.
- Transition FETCH to DRAIN when issue_left reaches 0.
- Output stream: ac_valid = buffer not empty. ac_word, ac_cmd, ac_ctl and ac_addr come from the buffer head. All four are stable while ac_valid && !ac_ready.
- A same-cycle buffer write and pop are both honoured and occupancy is unchanged. Words come out in issue order.
- Each accepted word decrements accept_left. When accept_left reaches 0, go to DONE.
- DONE: done=1 for exactly one cycle and busy=0 in that same cycle, then return to IDLE. A start arriving during DONE is ignored.
- word_count=64 reads all 64 words, wrapping as needed.
- ac_ready held low stalls issue within at most BUF_DEPTH outstanding words; no word is lost or duplicated.
- reset_n asserted mid-run clears everything immediately. The next run needs a fresh start.

Test Plan:
- Reset, then start with start_addr=0, word_count=4, ac_ready=1 -> ac_word sequence 0x0E070000, 0x0F070000, 0x0E070000, 0x0C070000; first ac_valid 3 cycles after start; done pulses once.
- start_addr=0x1C, word_count=3, ac_ready=1 -> words 0x06654008, 0x0E670000, 0x06050008. For the second word, ac_cmd=0xE, ac_ctl=0x67, ac_addr=0x0000.
- start_addr=0x3E, word_count=4 (wrap) -> rom_rdaddress goes 0x3E, 0x3F, 0x00, 0x01; words 0, 0, 0x0E070000, 0x0F070000.
- start_addr=0x04, word_count=12 with ac_ready toggling 1 of every 3 cycles -> exactly 12 in-order words 0x06000433 through 0x07990008; occupancy + in_flight never exceeds 4; ac_word stable while stalled.
- word_count=0 -> no rom_rdaddress change; done one cycle after start; busy=1 only in the start-acceptance cycle.
- Assert reset_n low after 5 of 20 words -> ac_valid=0, busy=0 immediately. Then start_addr=0x10, word_count=2 -> 0x07990000, 0x07994000.
